gs_rx_slicer: RTL
=================

GS_RX_SLICER -- requirements
Module: gs_rx_slicer

Interface
REQ-001 The block SHALL take two parameters: REF_INIT, default 18'd65536, the ref_level value after reset; ACC_LOG2, default 10, where 2^ACC_LOG2 is the symbols per reference-level update.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port clk_en, input, 1 bit: sample-rate enable, one receive-filter output sample per high cycle.
REQ-005 The block SHALL have port x_in, input, 18 bits: signed 1s17 receive-filter output sample, valid when clk_en=1.
REQ-006 The block SHALL have port phase_sel, input, 2 bits: which of 4 sample phases per symbol is the decision instant.
REQ-007 The block SHALL have port sym_out, output reg, 2 bits: 4-ASK decision, 00=-3a, 01=-a, 10=+a, 11=+3a.
REQ-008 The block SHALL have port sym_valid, output reg, 1 bit: one-clk pulse, sym_out/err_out updated.
REQ-009 The block SHALL have port err_out, output reg, 18 bits: signed slicer error, x minus ideal level, saturated.
REQ-010 The block SHALL have port ref_level, output reg, 18 bits: unsigned decision threshold (=2a), MSB always 0.
REQ-011 The block SHALL have port ref_update, output reg, 1 bit: one-clk pulse, ref_level just reloaded.

Function
REQ-012 A 2-bit phase counter SHALL increment (mod 4) on every clk with clk_en=1 and hold otherwise.
REQ-013 A decision instant SHALL be a clk edge with clk_en=1 and phase counter == phase_sel; a phase_sel change SHALL take effect on the next compare, with no realignment.
REQ-014 At a decision instant, sym_out SHALL register: 11 if x_in >= ref_level; 10 if 0 <= x_in < ref_level; 01 if -ref_level <= x_in < 0; 00 if x_in < -ref_level (compare at 19-bit signed).
REQ-015 The ideal level SHALL be +/-ref_level/2 for 10/01 and +/-(3*ref_level)/2 for 11/00 (arithmetic shift, truncate toward -inf, 20-bit intermediate).
REQ-016 err_out SHALL register x_in minus the ideal level, computed in 20 bits and saturated to [-131072, 131071].
REQ-017 sym_valid SHALL be 1 for exactly the clk following a decision instant and 0 otherwise; latency from x_in sample to sym_out is 1 clk.
REQ-018 Magnitude |x_in| SHALL be 18-bit unsigned, with -131072 saturated to 131071.
REQ-019 At each decision instant, a (17+ACC_LOG2+1)-bit accumulator SHALL add |x_in|, and an ACC_LOG2-bit symbol counter SHALL increment with wrap.
REQ-020 When the symbol counter is at its maximum value (1023 default) at a decision instant, ref_level SHALL load (acc + |x_in|) >> ACC_LOG2, the accumulator SHALL clear to 0, the counter SHALL wrap to 0, and ref_update SHALL pulse the next clk.
REQ-021 The decision and error at the same instant as a ref_level reload SHALL use the old ref_level.
REQ-022 With clk_en=0, all state SHALL hold and sym_valid/ref_update SHALL be 0.

Reset
REQ-023 While reset=1, asynchronously, the block SHALL hold: phase counter=0, symbol counter=0, accumulator=0, sym_out=00, sym_valid=0, err_out=0, ref_level=REF_INIT, ref_update=0.
REQ-024 Reset asserted mid-operation SHALL discard the partial accumulation; after release, the first clk_en edge SHALL be phase 0.

Verification
REQ-025 The bench SHALL apply reset, then phase_sel=0, clk_en=1 every clk, x_in=+20000; required response: first sym_valid 1 clk after the first edge, sym_out=10, err_out=-12768, ref_level=65536.
REQ-026 The bench SHALL continue REQ-025 to 1024 symbols; required response: ref_update pulses once, ref_level=20000, the 1024th decision is still 10, and the next decision is 11 with err_out=-10000.
REQ-027 The bench SHALL apply x_in=-131072 with ref_level=65536; required response: sym_out=00, err_out=-32768, and 131071 added to the accumulator.
REQ-028 The bench SHALL hold clk_en high 1 clk in 3 with phase_sel=2; required response: sym_valid every 12 clks, no pulses while clk_en=0, phase counter frozen between enables.
REQ-029 The bench SHALL apply x_in=0 for 1024 symbols; required response: ref_level=0, then x_in=0 gives sym_out=11 and err_out=0.
REQ-030 The bench SHALL assert reset at symbol 500 of an accumulation; required response: all outputs return to reset values immediately, and the next ref_update occurs 1024 symbols after release.

Source files
------------

// File: rtl/gs_rx_slicer.sv
// 4-ASK receive slicer: picks one sample phase per symbol, decides the symbol,
// reports the slicing error and tracks the decision threshold from mean |x|.
module gs_rx_slicer #(
    parameter logic [17:0] REF_INIT = 18'd65536,
    parameter int          ACC_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [17:0] x_in,
    input  logic [1:0]  phase_sel,
    output logic [1:0]  sym_out,
    output logic        sym_valid,
    output logic [17:0] err_out,
    output logic [17:0] ref_level,
    output logic        ref_update
);

    localparam int AW = ACC_LOG2 + 18;

    logic [1:0]          phase_q, phase_d;
    logic [ACC_LOG2-1:0] cnt_q, cnt_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [1:0]          sym_q, sym_d;
    logic                valid_q;
    logic [17:0]         err_q, err_d;
    logic [17:0]         ref_q, ref_d;
    logic                upd_q, upd_d;

    logic                decide;
    logic signed [18:0]  x19, ref19;
    logic signed [19:0]  ref20, ref3, ideal, diff;
    logic [17:0]         mag;
    logic [AW-1:0]       acc_sum;
    logic                last_sym;

    assign decide   = clk_en && (phase_q == phase_sel);
    assign x19      = {x_in[17], x_in};
    assign ref19    = {1'b0, ref_q};
    assign ref20    = {2'b00, ref_q};
    assign ref3     = ref20 + (ref20 <<< 1);
    assign last_sym = (cnt_q == {ACC_LOG2{1'b1}});
    assign acc_sum  = acc_q + {{ACC_LOG2{1'b0}}, mag};

    always_comb begin
        sym_d = 2'b00;
        if (x19 >= ref19)
            sym_d = 2'b11;
        else if (!x_in[17])
            sym_d = 2'b10;
        else if (x19 >= -ref19)
            sym_d = 2'b01;

        // Negative levels are shifted after negation, so odd thresholds round toward -inf.
        unique case (sym_d)
            2'b11:   ideal = ref3 >>> 1;
            2'b10:   ideal = ref20 >>> 1;
            2'b01:   ideal = (-ref20) >>> 1;
            default: ideal = (-ref3) >>> 1;
        endcase

        diff = {{2{x_in[17]}}, x_in} - ideal;
        if (diff > 20'sd131071)
            err_d = 18'h1FFFF;
        else if (diff < -20'sd131072)
            err_d = 18'h20000;
        else
            err_d = diff[17:0];

        if (x_in == 18'h20000)
            mag = 18'h1FFFF;
        else if (x_in[17])
            mag = -x_in;
        else
            mag = x_in;
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ref_d   = ref_q;
        upd_d   = 1'b0;
        if (clk_en)
            phase_d = phase_q + 2'd1;
        if (decide) begin
            cnt_d = cnt_q + {{(ACC_LOG2-1){1'b0}}, 1'b1};
            if (last_sym) begin
                ref_d = acc_sum[AW-1:ACC_LOG2];
                acc_d = '0;
                upd_d = 1'b1;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 2'd0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sym_q   <= 2'b00;
            valid_q <= 1'b0;
            err_q   <= 18'd0;
            ref_q   <= REF_INIT;
            upd_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ref_q   <= ref_d;
            upd_q   <= upd_d;
            valid_q <= decide;
            if (decide) begin
                sym_q <= sym_d;
                err_q <= err_d;
            end
        end
    end

    assign sym_out    = sym_q;
    assign sym_valid  = valid_q;
    assign err_out    = err_q;
    assign ref_level  = ref_q;
    assign ref_update = upd_q;

endmodule
